// File: rtl/weight_tile_fifo.sv
// weight_tile_fifo: circular weight-row FIFO for the systolic array weight-load path.
// Optional tile replay for weight reuse is built when WEIGHT_FIFO_REPLAY_EN is defined.
//
// Ports:
//   clk_i, rst_i      clock (posedge), synchronous active-high reset
//   write_i, data_i   push one row of LANES x DATA_W weights
//   full_o            no free row
//   read_i            pop/read one row
//   empty_o           no readable row
//   valid_o, data_o   registered read row, one cycle after an accepted read
//   tile_last_o       row returned is the last row of its tile
//   count_o           rows held (not yet freed)
//   err_o             sticky: write while full or read while empty
//   tile_keep_i       replay current tile on its last read (replay build only)
module weight_tile_fifo #(
    parameter int LANES       = 32,
    parameter int DATA_W      = 8,
    parameter int TILE_ROWS   = 32,
    parameter int DEPTH_TILES = 4,
    localparam int DEPTH      = TILE_ROWS * DEPTH_TILES,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           write_i,
    input  logic [LANES-1:0][DATA_W-1:0]   data_i,
    output logic                           full_o,
    input  logic                           read_i,
    output logic                           empty_o,
    output logic                           valid_o,
    output logic [LANES-1:0][DATA_W-1:0]   data_o,
    output logic                           tile_last_o,
    output logic [CNT_W-1:0]               count_o,
    output logic                           err_o,
    input  logic                           tile_keep_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam int ROW_W = LANES * DATA_W;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [ROW_W-1:0] mem_q [DEPTH];

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [ROW_W-1:0] data_q, data_d;

    logic wr_ok, rd_ok, is_last, full, empty;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign is_last = (row_idx_q == IDX_W'(TILE_ROWS - 1));

`ifdef WEIGHT_FIFO_REPLAY_EN
    // Rows of the tile being read stay resident until the tile is released,
    // so only rows past the current read position are readable.
    function automatic ptr_t ptr_rewind(input ptr_t p);
        int t;
        t = int'(p) - (TILE_ROWS - 1);
        if (t < 0) t = t + DEPTH;
        return ptr_t'(t);
    endfunction

    assign empty = ((count_q - CNT_W'(row_idx_q)) == '0);
`else
    logic unused_keep;
    assign unused_keep = tile_keep_i;
    assign empty       = (count_q == '0);
`endif

    assign wr_ok = write_i & ~full;
    assign rd_ok = read_i & ~empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        row_idx_d = row_idx_q;
        valid_d   = rd_ok;
        last_d    = rd_ok & is_last;
        data_d    = rd_ok ? mem_q[rd_ptr_q] : data_q;
        err_d     = err_q | (write_i & full) | (read_i & empty);

        if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);

        if (rd_ok) row_idx_d = is_last ? '0 : row_idx_q + 1'b1;

`ifdef WEIGHT_FIFO_REPLAY_EN
        count_d = count_q + CNT_W'(wr_ok);
        if (rd_ok) begin
            if (is_last && tile_keep_i) begin
                rd_ptr_d = ptr_rewind(rd_ptr_q);
            end else begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            // Whole tile released at once; modular add keeps the same-cycle write.
            if (is_last && !tile_keep_i) begin
                count_d = count_q + CNT_W'(wr_ok) - CNT_W'(TILE_ROWS);
            end
        end
`else
        count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            row_idx_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            row_idx_q <= row_idx_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign full_o      = full;
    assign empty_o     = empty;
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign tile_last_o = last_q;
    assign count_o     = count_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_weight_tile_fifo.sv
// tb_weight_tile_fifo: self-checking bench for weight_tile_fifo.
// Directed vector table, hand sequences and random traffic against a queue model.
module tb_weight_tile_fifo;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int TR     = 4;
    localparam int DT     = 2;
    localparam int DEPTH  = TR * DT;

    typedef logic [31:0] row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, wr, rd, keep;
    logic [LANES-1:0][DATA_W-1:0] din, dout;
    logic full, empty, valid, last, err;
    logic [3:0] cnt;

    int total = 0;
    int bad   = 0;

    weight_tile_fifo #(
        .LANES(LANES), .DATA_W(DATA_W), .TILE_ROWS(TR), .DEPTH_TILES(DT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .write_i(wr), .data_i(din), .full_o(full),
        .read_i(rd), .empty_o(empty), .valid_o(valid),
        .data_o(dout), .tile_last_o(last), .count_o(cnt),
        .err_o(err), .tile_keep_i(keep)
    );

    // ---------------- reference model ----------------
    row_t mq[$];
    int   m_idx;
    int   m_rd;
    bit   m_valid, m_last, m_err;
    row_t m_data;

    function automatic bit m_empty();
`ifdef WEIGHT_FIFO_REPLAY_EN
        return (mq.size() - m_idx) == 0;
`else
        return mq.size() == 0;
`endif
    endfunction

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_idx = 0; m_rd = 0;
        m_valid = 0; m_last = 0; m_err = 0; m_data = '0;
    endtask

    task automatic model_step(input bit w, input bit r, input bit k, input row_t d);
        bit f, e, acc_r, acc_w;
        f = m_full();
        e = m_empty();
        acc_w = w && !f;
        acc_r = r && !e;
        if ((w && f) || (r && e)) m_err = 1;
        m_valid = acc_r;
        m_last  = 0;
        if (acc_r) begin
`ifdef WEIGHT_FIFO_REPLAY_EN
            m_data = mq[m_idx];
            m_last = (m_idx == TR - 1);
            if (m_last) begin
                if (!k) repeat (TR) void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
`else
            m_data = mq.pop_front();
            m_last = (m_rd % TR) == TR - 1;
            m_rd++;
`endif
        end
        if (acc_w) mq.push_back(d);
    endtask

    // ---------------- helpers ----------------
    function automatic row_t mkrow(input int k);
        row_t r;
        for (int j = 0; j < LANES; j++) r[j*8 +: 8] = 8'(16 * k + j);
        return r;
    endfunction

    function automatic logic [40:0] obs();
        return {valid, last, err, empty, full, cnt, row_t'(dout)};
    endfunction

    function automatic logic [40:0] pack_exp(input bit v, input bit l, input bit er,
                                             input bit e, input bit f, input int c,
                                             input row_t d);
        return {v, l, er, e, f, 4'(c), d};
    endfunction

    task automatic check(input string nm, input logic [40:0] a, input logic [40:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic drive(input bit w, input bit r, input bit k, input row_t d);
        wr = w; rd = r; keep = k; din = d;
        @(posedge clk);
        model_step(w, r, k, d);
        #1;
    endtask

    task automatic step_chk(input string nm, input bit w, input bit r, input bit k,
                            input row_t d);
        drive(w, r, k, d);
        check(nm, obs(), pack_exp(m_valid, m_last, m_err, m_empty(), m_full(),
                                  mq.size(), m_data));
    endtask

    task automatic do_reset();
        rst = 1; wr = 0; rd = 0; keep = 0; din = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit   w; bit r; bit k; row_t d;
        bit   ev; bit el; bit eerr; bit ee; bit ef; int ec; row_t ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit w, input bit r, input bit k, input row_t d,
                       input bit ev, input bit el, input bit eerr, input bit ee,
                       input bit ef, input int ec, input row_t ed);
        vec_t v;
        v.w = w; v.r = r; v.k = k; v.d = d;
        v.ev = ev; v.el = el; v.eerr = eerr; v.ee = ee; v.ef = ef;
        v.ec = ec; v.ed = ed;
        tbl.push_back(v);
    endtask

    initial begin
        row_t rnd;
        // idle after reset
        add(0, 0, 0, '0, 0, 0, 0, 1, 0, 0, '0);
`ifdef WEIGHT_FIFO_REPLAY_EN
        for (int k = 0; k < 4; k++)
            add(1, 0, 0, mkrow(k), 0, 0, 0, 0, 0, k + 1, '0);
        for (int i = 0; i < 4; i++)
            add(0, 1, (i == 3), '0, 1, (i == 3), 0, 0, 0, 4, mkrow(i));
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, '0, 1, (i == 3), 0, (i == 3), 0,
                (i == 3) ? 0 : 4, mkrow(i));
        add(0, 1, 0, '0, 0, 0, 1, 1, 0, 0, mkrow(3));
`else
        for (int k = 0; k < 8; k++)
            add(1, 0, 0, mkrow(k), 0, 0, 0, 0, (k == 7), k + 1, '0);
        add(1, 0, 0, mkrow(8), 0, 0, 1, 0, 1, 8, '0);
        // keep asserted on tile-last reads must be ignored in this build
        for (int i = 0; i < 8; i++)
            add(0, 1, (i % 4 == 3), '0, 1, (i % 4 == 3), 1, (i == 7), 0,
                7 - i, mkrow(i));
        add(0, 1, 0, '0, 0, 0, 1, 1, 0, 0, mkrow(7));
`endif

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].k, tbl[i].d);
            check($sformatf("vec%0d", i), obs(),
                  pack_exp(tbl[i].ev, tbl[i].el, tbl[i].eerr, tbl[i].ee,
                           tbl[i].ef, tbl[i].ec, tbl[i].ed));
        end

        // wrap: 6w 6r 5w 5r
        do_reset();
        for (int i = 0; i < 6; i++) step_chk("wrap_w1", 1, 0, 0, row_t'($urandom));
        for (int i = 0; i < 6; i++) step_chk("wrap_r1", 0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step_chk("wrap_w2", 1, 0, 0, row_t'($urandom));
        for (int i = 0; i < 5; i++) step_chk("wrap_r2", 0, 1, 0, '0);
`ifndef WEIGHT_FIFO_REPLAY_EN
        check("wrap_cnt", {37'd0, cnt}, 41'd0);
`endif

        // read+write at count 3
        do_reset();
        for (int i = 0; i < 3; i++) step_chk("rw3_fill", 1, 0, 0, mkrow(i + 1));
        step_chk("rw3_both", 1, 1, 0, mkrow(9));
        check("rw3_cnt", {37'd0, cnt}, 41'd3);
        for (int i = 0; i < 3; i++) step_chk("rw3_drain", 0, 1, 0, '0);

        // read+write at full
        do_reset();
        for (int i = 0; i < 8; i++) step_chk("rwf_fill", 1, 0, 0, mkrow(i));
        step_chk("rwf_both", 1, 1, 0, mkrow(12));
`ifndef WEIGHT_FIFO_REPLAY_EN
        check("rwf_cnt_err", {36'd0, err, cnt}, {36'd0, 1'b1, 4'd7});
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rnd = row_t'($urandom);
            step_chk("rand", ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
                     $urandom_range(0, 1) == 1, rnd);
            if (i == 200) begin
                rst = 1;
                @(posedge clk);
                #1;
                rst = 0;
                model_reset();
                check("midreset", obs(), pack_exp(0, 0, 0, 1, 0, 0, '0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
